// File: rtl/booth_arb_ctrl_if.sv
// rtl/booth_arb_ctrl_if.sv - client request/operand and result bundle for booth_arb_ctrl
interface booth_arb_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 req0;
    logic [WIDTH-1:0]     m0;
    logic [WIDTH-1:0]     q0;
    logic                 req1;
    logic [WIDTH-1:0]     m1;
    logic [WIDTH-1:0]     q1;
    logic [1:0]           gnt;
    logic                 busy;
    logic                 done;
    logic                 done_id;
    logic [2*WIDTH-1:0]   product;

    // Multiplier side: takes requests and operands, returns grants and results.
    modport slave (
        input  req0, m0, q0, req1, m1, q1,
        output gnt, busy, done, done_id, product
    );

    // Client side.
    modport master (
        output req0, m0, q0, req1, m1, q1,
        input  gnt, busy, done, done_id, product
    );
endinterface

// File: rtl/booth_arb_ctrl.sv
// rtl/booth_arb_ctrl.sv - two-client round-robin arbiter feeding a radix-2 Booth multiplier
module booth_arb_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    booth_arb_ctrl_if.slave    arb_if
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q,   state_d;
    logic [WIDTH:0]       a_q,       a_d;
    logic [WIDTH:0]       m_q,       m_d;
    logic [WIDTH-1:0]     q_q,       q_d;
    logic                 qm1_q,     qm1_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic                 last_q,    last_d;
    logic                 cur_id_q,  cur_id_d;
    logic [1:0]           gnt_q,     gnt_d;
    logic                 done_q,    done_d;
    logic                 done_id_q, done_id_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 any_req;
    logic                 win_id;
    logic [WIDTH:0]       a_sum;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH-1:0]     q_shift;
    logic [WIDTH-1:0]     sel_m;
    logic [WIDTH-1:0]     sel_q;

    // Pick a winner: on contention the client not served last goes next.
    always_comb begin
        any_req = arb_if.req0 | arb_if.req1;
        if (arb_if.req0 && arb_if.req1) begin
            win_id = ~last_q;
        end else begin
            win_id = arb_if.req1;
        end
        sel_m = win_id ? arb_if.m1 : arb_if.m0;
        sel_q = win_id ? arb_if.q1 : arb_if.q0;
    end

    // One Booth step: add/subtract M by the {Q[0], q_m1} pair, then arithmetic shift right.
    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   a_sum = a_q + m_q;
            2'b10:   a_sum = a_q - m_q;
            default: a_sum = a_q;
        endcase
        a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_shift = {a_sum[0], q_q[WIDTH-1:1]};
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and datapath.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        cur_id_d  = cur_id_q;
        gnt_d     = 2'b00;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    m_d      = {sel_m[WIDTH-1], sel_m};
                    q_d      = sel_q;
                    a_d      = '0;
                    qm1_d    = 1'b0;
                    cnt_d    = CW'(WIDTH);
                    last_d   = win_id;
                    cur_id_d = win_id;
                    gnt_d    = win_id ? 2'b10 : 2'b01;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d   = a_shift;
                q_d   = q_shift;
                qm1_d = q_q[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    product_d = {a_shift[WIDTH-1:0], q_shift};
                    done_id_d = cur_id_q;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            cur_id_q  <= 1'b0;
            gnt_q     <= 2'b00;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            cur_id_q  <= cur_id_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            product_q <= product_d;
        end
    end

    assign arb_if.gnt     = gnt_q;
    assign arb_if.busy    = (state_q != IDLE);
    assign arb_if.done    = done_q;
    assign arb_if.done_id = done_id_q;
    assign arb_if.product = product_q;
endmodule

// File: doc/booth_arb_ctrl.md
BOOTH_ARB_CTRL -- requirements
Module: booth_arb_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  client 0 request; held high until gnt[0] is seen.
REQ-005 m0  input  WIDTH  client 0 multiplicand, signed two's complement.
REQ-006 q0  input  WIDTH  client 0 multiplier, signed two's complement.
REQ-007 req1, m1, q1  input  1, WIDTH, WIDTH  client 1 request and operands, same rules as client 0.
REQ-008 gnt  output  2  one-hot acceptance pulse; bit i means client i was accepted.
REQ-009 busy  output  1  high while a multiplication is in progress.
REQ-010 done  output  1  one-cycle result-valid pulse.
REQ-011 done_id  output  1  client index that owns the current result.
REQ-012 product  output  2*WIDTH  signed product; held stable until the next done.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE with req0 or req1 high SHALL, at the next edge, accept one client:
- capture that client's operands into M and Q;
- clear A and q_m1;
- load the step counter with WIDTH;
- go to RUN.
REQ-015 When both requests are high, the client that was not served last SHALL win; the last-served pointer resets to 1, so client 0 wins first.
REQ-016 gnt[i] SHALL be registered and high for exactly the first RUN cycle after accepting client i; all other cycles gnt = 2'b00.
REQ-017 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-018 Requests SHALL be ignored in RUN and DONE; a pending request is evaluated again on return to IDLE.
REQ-019 Each RUN edge SHALL perform one Booth step on pair {Q[0], q_m1}:
- 01: A = A + M;
- 10: A = A - M;
- 00 or 11: no change;
- then arithmetic right shift of {A, Q, q_m1} by one, with the sign bit of A replicated.
REQ-020 A SHALL be WIDTH+1 bits, with M sign-extended, so that M = -2^(WIDTH-1) produces no overflow.
REQ-021 The step counter SHALL decrement each RUN edge; the edge on which it goes from 1 to 0 SHALL move the FSM to DONE.
REQ-022 On that same edge:
- product SHALL be loaded with {A[WIDTH-1:0], Q}, the final shifted value;
- done_id SHALL be loaded with the served client's index.
REQ-023 done SHALL be high for exactly the single DONE cycle; DONE then goes to IDLE unconditionally.
REQ-024 Latency: done SHALL assert WIDTH+1 cycles after the accepting edge (9 cycles for WIDTH=8).
REQ-025 Throughput: a request already pending when the FSM returns to IDLE SHALL be accepted on the first IDLE edge, giving WIDTH+2 cycles per operation.
REQ-026 Operand input changes after acceptance SHALL NOT affect the result in progress.

Reset
REQ-027 While rst is high, the block SHALL set:
- state = IDLE;
- gnt = 0, busy = 0, done = 0, done_id = 0;
- product = 0;
- A, Q, M, q_m1 and counter = 0;
- last-served pointer = 1.
REQ-028 rst asserted mid-RUN SHALL abandon the operation with no done pulse and product unchanged at 0.
REQ-029 After rst deasserts, the next request SHALL be serviced normally.

Verification
REQ-030 Basic multiply: req0 with m0=3, q0=5 -> gnt=01 for one cycle, then done=1, done_id=0 and product=16'h000F, 9 cycles after the accept edge.
REQ-031 Signed multiply: req1 with m1=7, q1=-3 (8'hFD) -> product=16'hFFEB (-21), done_id=1.
REQ-032 Overflow corner: m0=-128, q0=-128 -> product=16'h4000; also check m0=-128, q0=1 -> 16'hFF80.
REQ-033 Arbitration: req0 and req1 both high from reset and held until granted:
- client 0 is served first (client 0 first wins because last-served resets to 1);
- client 1 is then accepted on the first IDLE edge;
- two done pulses occur 10 cycles apart, with done_id 0 then 1.
REQ-034 Fairness: req0 held high continuously while req1 is also requested -> grants alternate 0, 1, 0, 1.
REQ-035 Reset mid-operation: rst pulsed during the 4th RUN cycle -> busy=0, done never pulses, product=0; a following req0 with 2*2 gives product=16'h0004.
